// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - command handshake interface for counter_ctrl
//
// Purpose: bundles the software command port (valid/ready handshake plus
// opcode and load data) into one interface.
// Signals:
//   cmd_valid  source -> sink  command present
//   cmd_ready  sink -> source  command can be accepted this cycle
//   cmd_op     source -> sink  00 START, 01 STOP, 10 CLEAR, 11 LOAD
//   cmd_data   source -> sink  load value, used by LOAD only
// Modports: master = command source, slave = counter_ctrl.

interface counter_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - control sequencer for the free-running up-counter
//
// Purpose: start/stop/clear/load command handling, programmable terminal
// value, one-shot or auto-reload operation, sticky irq with overrun flag.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   cmd         slave modport of counter_ctrl_if (valid/ready/op/data)
//   cfg_period  in   terminal count, sampled live every cycle
//   cfg_reload  in   1 auto-reload, 0 one-shot
//   irq_ack     in   clears irq and ovr
//   count       out  current counter value
//   running     out  1 while state is RUN
//   irq         out  sticky terminal-count interrupt
//   ovr         out  sticky: terminal count hit while irq already set

module counter_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_ctrl_if.slave      cmd,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic               cfg_reload,
  input  logic               irq_ack,
  output logic [WIDTH-1:0]   count,
  output logic               running,
  output logic               irq,
  output logic               ovr
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             running_q;
  logic             irq_q;
  logic             irq_d;
  logic             ovr_q;
  logic             ovr_d;
  logic             accept;
  logic             terminal_evt;

  // A finished one-shot with an unacknowledged irq back-pressures software
  // so a pending START cannot silently discard the completion.
  assign cmd.cmd_ready = !((state_q == S_DONE) && irq_q);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == S_RUN);
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    terminal_evt = 1'b0;

    if (accept) begin
      // An accepted command pre-empts the increment and terminal check.
      unique case (cmd.cmd_op)
        OP_START: begin
          if (state_q == S_DONE) begin
            state_d = S_RUN;
            count_d = '0;
          end else if (state_q != S_RUN) begin
            state_d = S_RUN;
          end
        end
        OP_STOP: begin
          if (state_q == S_RUN) begin
            state_d = S_PAUSE;
          end
        end
        OP_CLEAR: begin
          state_d = S_IDLE;
          count_d = '0;
        end
        OP_LOAD: begin
          count_d = cmd.cmd_data;
          if (state_q == S_DONE) begin
            state_d = S_PAUSE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (state_q == S_RUN) begin
      if (count_q == cfg_period) begin
        terminal_evt = 1'b1;
        if (cfg_reload) begin
          count_d = '0;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        // Natural wrap at all-ones is not a terminal event.
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // irq_ack and a terminal event in the same cycle: the event keeps irq
  // set, while ovr is only raised by an event that finds irq already set
  // and is not being acknowledged.
  always_comb begin
    irq_d = irq_q;
    ovr_d = ovr_q;
    if (irq_ack) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (terminal_evt) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) begin
        ovr_d = 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign irq     = irq_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl

module tb_counter_ctrl;

  localparam int W = 32;
  localparam logic [1:0] START = 2'b00;
  localparam logic [1:0] STOP  = 2'b01;
  localparam logic [1:0] CLEAR = 2'b10;
  localparam logic [1:0] LOAD  = 2'b11;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] cfg_period;
  logic         cfg_reload;
  logic         irq_ack;
  logic [W-1:0] count;
  logic         running;
  logic         irq;
  logic         ovr;

  int n_cmp;
  int n_fail;

  // reference model state
  int           m_state;
  logic [W-1:0] m_count;
  bit           m_irq;
  bit           m_ovr;
  bit           m_acc;

  counter_ctrl_if #(.WIDTH(W)) cif ();

  counter_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif.slave),
    .cfg_period (cfg_period),
    .cfg_reload (cfg_reload),
    .irq_ack    (irq_ack),
    .count      (count),
    .running    (running),
    .irq        (irq),
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = START;
    cif.cmd_data  = '0;
    irq_ack       = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_state = M_IDLE;
    m_count = '0;
    m_irq   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Reference: what one rising edge does, given current inputs.
  task automatic model_edge();
    bit hit;
    bit rdy;
    hit = 1'b0;
    rdy = !(m_state == M_DONE && m_irq);
    m_acc = cif.cmd_valid && rdy;
    if (m_acc) begin
      if (cif.cmd_op == START && m_state != M_RUN) begin
        if (m_state == M_DONE) m_count = 0;
        m_state = M_RUN;
      end else if (cif.cmd_op == STOP && m_state == M_RUN) begin
        m_state = M_PAUSE;
      end else if (cif.cmd_op == CLEAR) begin
        m_state = M_IDLE;
        m_count = 0;
      end else if (cif.cmd_op == LOAD) begin
        m_count = cif.cmd_data;
        if (m_state == M_DONE) m_state = M_PAUSE;
      end
    end else if (m_state == M_RUN) begin
      if (m_count == cfg_period) begin
        hit = 1'b1;
        if (cfg_reload) m_count = 0;
        else m_state = M_DONE;
      end else begin
        m_count = m_count + 1;
      end
    end
    if (hit && m_irq && !irq_ack) m_ovr = 1'b1;
    else if (irq_ack) m_ovr = 1'b0;
    if (hit) m_irq = 1'b1;
    else if (irq_ack) m_irq = 1'b0;
  endtask

  task automatic test_reset();
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = START;
    cif.cmd_data  = '0;
    irq_ack       = 1'b0;
    cfg_period    = 32'd4;
    cfg_reload    = 1'b1;
    rst_n         = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({count, running, irq, ovr, cif.cmd_ready} !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got count=%h run=%b irq=%b ovr=%b rdy=%b, want 0 0 0 0 1",
               count, running, irq, ovr, cif.cmd_ready);
    end
    rst_n = 1'b1;
    tick();
    m_state = M_IDLE;
    m_count = '0;
    m_irq   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic test_autoreload();
    do_reset();
    cfg_period = 32'd4;
    cfg_reload = 1'b1;
    issue(START, '0);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (count !== 32'(k % 5) || irq !== (k == 5) || running !== 1'b1) begin
        n_fail++;
        $display("FAIL autoreload step %0d: got count=%0d irq=%b run=%b, want count=%0d irq=%b run=1",
                 k, count, irq, running, k % 5, (k == 5));
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    cfg_period = 32'd3;
    cfg_reload = 1'b0;
    issue(START, '0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (count !== 32'(k) || running !== 1'b1 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot count %0d: got count=%0d run=%b irq=%b", k, count, running, irq);
      end
    end
    tick();
    n_cmp++;
    if (count !== 32'd3 || running !== 1'b0 || irq !== 1'b1 || cif.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_done: got count=%0d run=%b irq=%b rdy=%b, want 3 0 1 0",
               count, running, irq, cif.cmd_ready);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_cmp++;
    if (irq !== 1'b0 || cif.cmd_ready !== 1'b1 || count !== 32'd3) begin
      n_fail++;
      $display("FAIL oneshot_ack: got irq=%b rdy=%b count=%0d, want 0 1 3", irq, cif.cmd_ready, count);
    end
    issue(START, '0);
    n_cmp++;
    if (count !== 32'd0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_restart: got count=%0d run=%b, want 0 1", count, running);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    cfg_period = 32'd2;
    cfg_reload = 1'b1;
    issue(START, '0);
    repeat (3) tick();
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b1 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_first: got count=%0d irq=%b ovr=%b, want 0 1 0", count, irq, ovr);
    end
    repeat (3) tick();
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b1 || ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_second: got count=%0d irq=%b ovr=%b, want 0 1 1", count, irq, ovr);
    end
    repeat (2) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b1 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_with_terminal: got count=%0d irq=%b ovr=%b, want 0 1 0", count, irq, ovr);
    end
  endtask

  task automatic test_stop_load_wrap();
    do_reset();
    cfg_period = 32'd100;
    cfg_reload = 1'b1;
    issue(START, '0);
    repeat (10) tick();
    issue(STOP, '0);
    tick();
    n_cmp++;
    if (count !== 32'd10 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_hold: got count=%0d run=%b, want 10 0", count, running);
    end
    cfg_period = 32'd5;
    issue(LOAD, 32'hFFFF_FFFE);
    n_cmp++;
    if (count !== 32'hFFFF_FFFE || running !== 1'b0) begin
      n_fail++;
      $display("FAIL load_pause: got count=%h run=%b, want fffffffe 0", count, running);
    end
    issue(START, '0);
    tick();
    n_cmp++;
    if (count !== 32'hFFFF_FFFF || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_max: got count=%h irq=%b, want ffffffff 0", count, irq);
    end
    tick();
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_zero: got count=%h irq=%b, want 0 0", count, irq);
    end
    repeat (5) tick();
    n_cmp++;
    if (count !== 32'd5 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_at5: got count=%0d irq=%b, want 5 0", count, irq);
    end
    tick();
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_terminal: got count=%0d irq=%b, want 0 1", count, irq);
    end
  endtask

  task automatic test_clear_async_reset();
    // continues from test_stop_load_wrap: RUN with irq set
    issue(CLEAR, '0);
    n_cmp++;
    if (count !== 32'd0 || running !== 1'b0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_in_run: got count=%0d run=%b irq=%b, want 0 0 1", count, running, irq);
    end
    issue(START, '0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, running, irq, ovr, cif.cmd_ready} !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got count=%0d run=%b irq=%b ovr=%b rdy=%b, want 0 0 0 0 1",
               count, running, irq, ovr, cif.cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_period_zero();
    do_reset();
    cfg_period = 32'd0;
    cfg_reload = 1'b1;
    issue(START, '0);
    tick();
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b1 || ovr !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_first: got count=%0d irq=%b ovr=%b run=%b, want 0 1 0 1", count, irq, ovr, running);
    end
    tick();
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b1 || ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_second: got count=%0d irq=%b ovr=%b, want 0 1 1", count, irq, ovr);
    end
    do_reset();
    cfg_reload = 1'b0;
    issue(START, '0);
    tick();
    n_cmp++;
    if (count !== 32'd0 || irq !== 1'b1 || running !== 1'b0 || cif.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL p0_oneshot: got count=%0d irq=%b run=%b rdy=%b, want 0 1 0 0",
               count, irq, running, cif.cmd_ready);
    end
  endtask

  task automatic test_random();
    bit pending;
    do_reset();
    pending    = 1'b0;
    cfg_period = 32'd5;
    cfg_reload = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!pending && ($urandom % 4 == 0)) begin
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'($urandom % 4);
        cif.cmd_data  = 32'($urandom_range(0, 12));
        pending       = 1'b1;
      end
      if ($urandom % 50 == 0) cfg_period = 32'($urandom_range(0, 10));
      if ($urandom % 80 == 0) cfg_reload = ~cfg_reload;
      irq_ack = ($urandom % 6 == 0);
      model_edge();
      tick();
      if (m_acc) begin
        pending       = 1'b0;
        cif.cmd_valid = 1'b0;
      end
      n_cmp++;
      if (count !== m_count || running !== (m_state == M_RUN) || irq !== m_irq || ovr !== m_ovr ||
          cif.cmd_ready !== !(m_state == M_DONE && m_irq)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got count=%0d run=%b irq=%b ovr=%b rdy=%b, want count=%0d run=%b irq=%b ovr=%b rdy=%b",
                 i, count, running, irq, ovr, cif.cmd_ready, m_count, (m_state == M_RUN),
                 m_irq, m_ovr, !(m_state == M_DONE && m_irq));
      end
    end
    irq_ack       = 1'b0;
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_autoreload();
    test_oneshot();
    test_overrun();
    test_stop_load_wrap();
    test_clear_async_reset();
    test_period_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
